// File: rtl/io_multichannel_sequencer.sv
// rtl/io_multichannel_sequencer.sv - concurrent timed IO command sequencer
// Up to CHANNELS pulse/delayed-pulse/sample timers plus immediate SET/CANCEL, one tagged response each.
module io_multichannel_sequencer #(
    parameter int OUTPUTS  = 32,
    parameter int INPUTS   = 32,
    parameter int PIN_W    = 5,
    parameter int CHANNELS = 4,
    parameter int CH_W     = 2,
    parameter int TIMER_W  = 44
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [2:0]         cmd_op,
    input  logic [PIN_W-1:0]   cmd_pin,
    input  logic [TIMER_W-1:0] cmd_delay,
    input  logic [TIMER_W-1:0] cmd_hold,
    input  logic               cmd_level,
    input  logic [INPUTS-1:0]  input_io,
    output logic [OUTPUTS-1:0] output_io,
    output logic               rsp_valid,
    output logic               rsp_imm,
    output logic [CH_W-1:0]    rsp_chan,
    output logic               rsp_data,
    output logic               rsp_err,
    output logic               busy
);
    typedef enum logic [1:0] {S_IDLE, S_DELAY, S_HOLD, S_DONE} ch_state_e;

    localparam logic [2:0] OP_PULSE  = 3'd0;
    localparam logic [2:0] OP_DPULSE = 3'd1;
    localparam logic [2:0] OP_SET    = 3'd2;
    localparam logic [2:0] OP_SAMPLE = 3'd3;
    localparam logic [2:0] OP_CANCEL = 3'd4;

    ch_state_e          st_q   [CHANNELS];
    ch_state_e          st_d   [CHANNELS];
    logic [TIMER_W-1:0] cnt_q  [CHANNELS];
    logic [TIMER_W-1:0] cnt_d  [CHANNELS];
    logic [TIMER_W-1:0] hold_q [CHANNELS];
    logic [TIMER_W-1:0] hold_d [CHANNELS];
    logic [PIN_W-1:0]   pin_q  [CHANNELS];
    logic [PIN_W-1:0]   pin_d  [CHANNELS];
    logic               smp_q  [CHANNELS];
    logic               smp_d  [CHANNELS];
    logic               data_q [CHANNELS];
    logic               data_d [CHANNELS];

    logic [OUTPUTS-1:0] out_q, out_d;
    logic               imm_pend_q, imm_pend_d, imm_err_q, imm_err_d;
    logic               rsp_valid_q, rsp_valid_d, rsp_imm_q, rsp_imm_d;
    logic               rsp_data_q, rsp_data_d, rsp_err_q, rsp_err_d;
    logic [CH_W-1:0]    rsp_chan_q, rsp_chan_d;

    logic               free_found, own_found, done_found, accept;
    logic [CH_W-1:0]    free_idx, own_idx, done_idx;
    logic [TIMER_W-1:0] hold_norm;

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        own_found  = 1'b0;
        own_idx    = '0;
        done_found = 1'b0;
        done_idx   = '0;
        busy       = 1'b0;
        // Only pulse channels own their pin; samples never block or get cancelled.
        for (int i = 0; i < CHANNELS; i++) begin
            if (st_q[i] == S_IDLE && !free_found) begin
                free_found = 1'b1;
                free_idx   = CH_W'(i);
            end
            if (st_q[i] != S_IDLE && !smp_q[i] && pin_q[i] == cmd_pin) begin
                own_found = 1'b1;
                own_idx   = CH_W'(i);
            end
            if (st_q[i] == S_DONE && !done_found) begin
                done_found = 1'b1;
                done_idx   = CH_W'(i);
            end
            if (st_q[i] != S_IDLE) begin
                busy = 1'b1;
            end
        end
        cmd_ready = free_found;
        accept    = cmd_valid && free_found;
        hold_norm = (cmd_hold == '0) ? TIMER_W'(1) : cmd_hold;

        st_d        = st_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        pin_d       = pin_q;
        smp_d       = smp_q;
        data_d      = data_q;
        out_d       = out_q;
        imm_pend_d  = 1'b0;
        imm_err_d   = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_imm_d   = 1'b0;
        rsp_chan_d  = '0;
        rsp_data_d  = 1'b0;
        rsp_err_d   = 1'b0;

        if (imm_pend_q) begin
            rsp_valid_d = 1'b1;
            rsp_imm_d   = 1'b1;
            rsp_err_d   = imm_err_q;
        end else if (done_found) begin
            rsp_valid_d      = 1'b1;
            rsp_chan_d       = done_idx;
            rsp_data_d       = data_q[done_idx];
            st_d[done_idx]   = S_IDLE;
        end

        for (int i = 0; i < CHANNELS; i++) begin
            case (st_q[i])
                S_DELAY: begin
                    if (smp_q[i]) begin
                        if (cnt_q[i] == '0) begin
                            data_d[i] = input_io[pin_q[i]];
                            st_d[i]   = S_DONE;
                        end else begin
                            cnt_d[i] = cnt_q[i] - TIMER_W'(1);
                        end
                    end else if (cnt_q[i] == TIMER_W'(1)) begin
                        st_d[i]          = S_HOLD;
                        cnt_d[i]         = hold_q[i];
                        out_d[pin_q[i]]  = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] - TIMER_W'(1);
                    end
                end
                S_HOLD: begin
                    if (cnt_q[i] == TIMER_W'(1)) begin
                        st_d[i]         = S_DONE;
                        out_d[pin_q[i]] = 1'b0;
                    end else begin
                        cnt_d[i] = cnt_q[i] - TIMER_W'(1);
                    end
                end
                default: ;
            endcase
        end

        // Commands are applied last so CANCEL overrides a same-edge channel transition.
        if (accept) begin
            case (cmd_op)
                OP_PULSE, OP_DPULSE: begin
                    if (own_found) begin
                        imm_pend_d = 1'b1;
                        imm_err_d  = 1'b1;
                    end else begin
                        pin_d[free_idx]  = cmd_pin;
                        smp_d[free_idx]  = 1'b0;
                        data_d[free_idx] = 1'b0;
                        hold_d[free_idx] = hold_norm;
                        if (cmd_op == OP_DPULSE && cmd_delay != '0) begin
                            st_d[free_idx]  = S_DELAY;
                            cnt_d[free_idx] = cmd_delay;
                        end else begin
                            st_d[free_idx]  = S_HOLD;
                            cnt_d[free_idx] = hold_norm;
                            out_d[cmd_pin]  = 1'b1;
                        end
                    end
                end
                OP_SET: begin
                    imm_pend_d = 1'b1;
                    if (own_found) begin
                        imm_err_d = 1'b1;
                    end else begin
                        out_d[cmd_pin] = cmd_level;
                    end
                end
                OP_SAMPLE: begin
                    pin_d[free_idx]  = cmd_pin;
                    smp_d[free_idx]  = 1'b1;
                    data_d[free_idx] = 1'b0;
                    hold_d[free_idx] = '0;
                    st_d[free_idx]   = S_DELAY;
                    cnt_d[free_idx]  = cmd_delay;
                end
                OP_CANCEL: begin
                    imm_pend_d = 1'b1;
                    if (own_found) begin
                        st_d[own_idx]         = S_IDLE;
                        out_d[pin_q[own_idx]] = 1'b0;
                    end else begin
                        imm_err_d = 1'b1;
                    end
                end
                default: begin
                    imm_pend_d = 1'b1;
                    imm_err_d  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                st_q[i]   <= S_IDLE;
                cnt_q[i]  <= '0;
                hold_q[i] <= '0;
                pin_q[i]  <= '0;
                smp_q[i]  <= 1'b0;
                data_q[i] <= 1'b0;
            end
            out_q       <= '0;
            imm_pend_q  <= 1'b0;
            imm_err_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_imm_q   <= 1'b0;
            rsp_chan_q  <= '0;
            rsp_data_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            st_q        <= st_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            pin_q       <= pin_d;
            smp_q       <= smp_d;
            data_q      <= data_d;
            out_q       <= out_d;
            imm_pend_q  <= imm_pend_d;
            imm_err_q   <= imm_err_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_imm_q   <= rsp_imm_d;
            rsp_chan_q  <= rsp_chan_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign output_io = out_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_imm   = rsp_imm_q;
    assign rsp_chan  = rsp_chan_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_io_multichannel_sequencer.sv
// tb/tb_io_multichannel_sequencer.sv - bench for io_multichannel_sequencer
// Reference model tracks each channel as absolute edge times (rise, fall, sample, done).
module tb_io_multichannel_sequencer;
    localparam int PIN_W   = 5;
    localparam int CH_W    = 2;
    localparam int TIMER_W = 44;
    localparam int NCH     = 4;

    localparam logic [2:0] OP_PULSE  = 3'd0;
    localparam logic [2:0] OP_DPULSE = 3'd1;
    localparam logic [2:0] OP_SET    = 3'd2;
    localparam logic [2:0] OP_SAMPLE = 3'd3;
    localparam logic [2:0] OP_CANCEL = 3'd4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic [2:0]         cmd_op = '0;
    logic [PIN_W-1:0]   cmd_pin = '0;
    logic [TIMER_W-1:0] cmd_delay = '0;
    logic [TIMER_W-1:0] cmd_hold = '0;
    logic               cmd_level = 1'b0;
    logic [31:0]        input_io = '0;
    logic [31:0]        output_io;
    logic               rsp_valid, rsp_imm, rsp_data, rsp_err, busy;
    logic [CH_W-1:0]    rsp_chan;

    always #5 clk = ~clk;

    io_multichannel_sequencer #(
        .OUTPUTS(32), .INPUTS(32), .PIN_W(PIN_W), .CHANNELS(NCH), .CH_W(CH_W), .TIMER_W(TIMER_W)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_pin(cmd_pin), .cmd_delay(cmd_delay), .cmd_hold(cmd_hold), .cmd_level(cmd_level),
        .input_io(input_io), .output_io(output_io), .rsp_valid(rsp_valid), .rsp_imm(rsp_imm),
        .rsp_chan(rsp_chan), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
    );

    int n_chk = 0;
    int n_fail = 0;

    bit          m_act  [NCH];
    bit          m_smp  [NCH];
    int          m_pin  [NCH];
    longint      m_rise [NCH];
    longint      m_fall [NCH];
    longint      m_done [NCH];
    bit          m_data [NCH];
    logic [31:0] m_out;
    bit          m_pend, m_perr;
    logic [5:0]  m_rsp;
    longint      t_edge = 0;
    bit          dut_acc;

    typedef struct {
        logic [2:0] op;
        int         pin;
        bit         lvl;
        bit         exp_err;
        bit         exp_bit;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_any_free();
        bit r = 1'b0;
        for (int i = 0; i < NCH; i++) if (!m_act[i]) r = 1'b1;
        return r;
    endfunction

    function automatic bit m_any_busy();
        bit r = 1'b0;
        for (int i = 0; i < NCH; i++) if (m_act[i]) r = 1'b1;
        return r;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NCH; i++) m_act[i] = 1'b0;
        m_out  = '0;
        m_pend = 1'b0;
        m_perr = 1'b0;
        m_rsp  = '0;
        t_edge++;
    endtask

    task automatic m_step(input bit v, input logic [2:0] op, input int pin, input longint d,
                          input longint h, input bit lvl);
        int fr = -1;
        int own = -1;
        int dn = -1;
        int gr = -1;
        longint hn;
        for (int i = 0; i < NCH; i++) begin
            if (!m_act[i] && fr < 0) fr = i;
            if (m_act[i] && !m_smp[i] && m_pin[i] == pin) own = i;
            if (m_act[i] && m_done[i] < t_edge && dn < 0) dn = i;
        end
        m_rsp = '0;
        if (m_pend) m_rsp = {1'b1, 1'b1, 2'b00, 1'b0, m_perr};
        else if (dn >= 0) begin
            m_rsp = {1'b1, 1'b0, 2'(dn), m_data[dn], 1'b0};
            gr = dn;
        end
        m_pend = 1'b0;
        m_perr = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (m_act[i]) begin
                if (!m_smp[i]) begin
                    if (t_edge == m_rise[i]) m_out[m_pin[i]] = 1'b1;
                    if (t_edge == m_fall[i]) m_out[m_pin[i]] = 1'b0;
                end else if (t_edge == m_done[i]) begin
                    m_data[i] = input_io[m_pin[i]];
                end
            end
        end
        if (gr >= 0) m_act[gr] = 1'b0;
        if (v && fr >= 0) begin
            hn = (h == 0) ? 1 : h;
            case (op)
                OP_PULSE, OP_DPULSE: begin
                    if (own >= 0) begin
                        m_pend = 1'b1;
                        m_perr = 1'b1;
                    end else begin
                        m_act[fr]  = 1'b1;
                        m_smp[fr]  = 1'b0;
                        m_pin[fr]  = pin;
                        m_data[fr] = 1'b0;
                        m_rise[fr] = t_edge + ((op == OP_DPULSE) ? d : 0);
                        m_fall[fr] = m_rise[fr] + hn;
                        m_done[fr] = m_fall[fr];
                        if (m_rise[fr] == t_edge) m_out[pin] = 1'b1;
                    end
                end
                OP_SET: begin
                    m_pend = 1'b1;
                    if (own >= 0) m_perr = 1'b1;
                    else m_out[pin] = lvl;
                end
                OP_SAMPLE: begin
                    m_act[fr]  = 1'b1;
                    m_smp[fr]  = 1'b1;
                    m_pin[fr]  = pin;
                    m_data[fr] = 1'b0;
                    m_rise[fr] = -1;
                    m_fall[fr] = -1;
                    m_done[fr] = t_edge + d + 1;
                end
                OP_CANCEL: begin
                    m_pend = 1'b1;
                    if (own >= 0) begin
                        m_act[own]  = 1'b0;
                        m_out[pin]  = 1'b0;
                    end else begin
                        m_perr = 1'b1;
                    end
                end
                default: begin
                    m_pend = 1'b1;
                    m_perr = 1'b1;
                end
            endcase
        end
        t_edge++;
    endtask

    task automatic cmp_all();
        chk("output_io", 64'(output_io), 64'(m_out));
        chk("rsp", 64'({rsp_valid, rsp_imm, rsp_chan, rsp_data, rsp_err}), 64'(m_rsp));
        chk("ready_busy", 64'({cmd_ready, busy}), 64'({m_any_free(), m_any_busy()}));
    endtask

    task automatic cyc(input bit v, input logic [2:0] op, input int pin, input longint d,
                       input longint h, input bit lvl);
        @(negedge clk);
        rst       = 1'b0;
        cmd_valid = v;
        cmd_op    = op;
        cmd_pin   = PIN_W'(pin);
        cmd_delay = TIMER_W'(d);
        cmd_hold  = TIMER_W'(h);
        cmd_level = lvl;
        #1;
        dut_acc = cmd_valid && cmd_ready;
        m_step(v, op, pin, d, h, lvl);
        @(posedge clk);
        #1;
        cmp_all();
    endtask

    task automatic idle();
        cyc(1'b0, 3'd0, 0, 0, 0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        cmd_valid = 1'b0;
        m_reset();
        @(posedge clk);
        #1;
        cmp_all();
    endtask

    initial begin
        int acc_k;
        int extra_rsp;

        tbl[0] = '{OP_SET,    4,  1'b1, 1'b0, 1'b1};
        tbl[1] = '{OP_SET,    4,  1'b0, 1'b0, 1'b0};
        tbl[2] = '{3'd5,      0,  1'b0, 1'b1, 1'b0};
        tbl[3] = '{3'd6,      12, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{3'd7,      9,  1'b1, 1'b1, 1'b0};
        tbl[5] = '{OP_CANCEL, 12, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{OP_SET,    31, 1'b1, 1'b0, 1'b1};

        do_reset();
        chk("reset_out", 64'(output_io), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);

        for (int i = 0; i < 7; i++) begin
            cyc(1'b1, tbl[i].op, tbl[i].pin, 0, 0, tbl[i].lvl);
            idle();
            chk("tbl_rsp", 64'({rsp_valid, rsp_imm, rsp_err}), 64'({2'b11, tbl[i].exp_err}));
            chk("tbl_pin", 64'(output_io[tbl[i].pin]), 64'(tbl[i].exp_bit));
            chk("tbl_busy", 64'(busy), 64'd0);
            idle();
        end

        // Single PULSE timing and response cycle.
        do_reset();
        cyc(1'b1, OP_PULSE, 3, 0, 4, 1'b0);
        chk("A_pin3", 64'(output_io[3]), 64'd1);
        for (int k = 1; k <= 6; k++) begin
            idle();
            chk("A_pin3", 64'(output_io[3]), 64'(k <= 3));
            if (k == 5) chk("A_rsp", 64'({rsp_valid, rsp_imm, rsp_chan, rsp_data, rsp_err}), 64'b100000);
        end

        // DPULSE and a zero-delay SAMPLE on a second channel.
        do_reset();
        input_io = 32'h0000_0200;
        cyc(1'b1, OP_DPULSE, 7, 10, 2, 1'b0);
        cyc(1'b1, OP_SAMPLE, 9, 0, 0, 1'b0);
        for (int k = 2; k <= 20; k++) begin
            idle();
            if (k == 3) chk("B_sample_rsp", 64'({rsp_valid, rsp_imm, rsp_chan, rsp_data, rsp_err}), 64'b100110);
            if (k >= 9 && k <= 12) chk("B_pin7", 64'(output_io[7]), 64'(k == 10 || k == 11));
        end

        // All channels busy; a fifth command stalls until channel 0 is released.
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1'b1, OP_PULSE, i, 0, 100, 1'b0);
        chk("C_ready_full", 64'(cmd_ready), 64'd0);
        chk("C_busy_full", 64'(busy), 64'd1);
        acc_k = -1;
        for (int k = 0; k < 300 && acc_k < 0; k++) begin
            cyc(1'b1, OP_SET, 20, 0, 0, 1'b1);
            if (dut_acc) acc_k = k;
        end
        chk("C_stall_len", 64'(acc_k), 64'd98);
        for (int k = 0; k < 10; k++) idle();

        // Conflicting SET, then CANCEL of the owning pulse.
        do_reset();
        cyc(1'b1, OP_PULSE, 5, 0, 50, 1'b0);
        cyc(1'b1, OP_SET, 5, 0, 0, 1'b1);
        idle();
        chk("D_set_rsp", 64'({rsp_valid, rsp_imm, rsp_chan, rsp_data, rsp_err}), 64'b110001);
        chk("D_pin5_kept", 64'(output_io[5]), 64'd1);
        for (int k = 3; k < 20; k++) idle();
        cyc(1'b1, OP_CANCEL, 5, 0, 0, 1'b0);
        chk("D_pin5_cancel", 64'(output_io[5]), 64'd0);
        idle();
        chk("D_cancel_rsp", 64'({rsp_valid, rsp_imm, rsp_chan, rsp_data, rsp_err}), 64'b110000);
        extra_rsp = 0;
        for (int k = 22; k <= 60; k++) begin
            idle();
            if (rsp_valid) extra_rsp++;
        end
        chk("D_no_chan_rsp", 64'(extra_rsp), 64'd0);

        // Reset in the middle of a HOLD.
        do_reset();
        cyc(1'b1, OP_PULSE, 2, 0, 20, 1'b0);
        for (int k = 0; k < 4; k++) idle();
        chk("F_pin2_high", 64'(output_io[2]), 64'd1);
        do_reset();
        chk("F_pin2_low", 64'(output_io[2]), 64'd0);
        chk("F_busy", 64'(busy), 64'd0);
        extra_rsp = 0;
        for (int k = 0; k < 30; k++) begin
            idle();
            if (rsp_valid) extra_rsp++;
        end
        chk("F_no_rsp", 64'(extra_rsp), 64'd0);

        // Randomised traffic on a small pin set to provoke conflicts and stalls.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            int r;
            logic [2:0] op;
            input_io = $urandom();
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                r = int'($urandom_range(0, 15));
                if (r < 4) op = OP_PULSE;
                else if (r < 7) op = OP_DPULSE;
                else if (r < 9) op = OP_SET;
                else if (r < 12) op = OP_SAMPLE;
                else if (r < 14) op = OP_CANCEL;
                else op = 3'($urandom_range(5, 7));
                cyc(1'($urandom_range(0, 1)), op, int'($urandom_range(0, 7)),
                    longint'($urandom_range(0, 6)), longint'($urandom_range(0, 6)),
                    1'($urandom_range(0, 1)));
            end
        end
        for (int k = 0; k < 40; k++) idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/io_multichannel_sequencer.md
Name: io_multichannel_sequencer

Overview:
- Parametrised successor to the single-command IO sequencer.
- Runs up to CHANNELS timed IO commands concurrently: pulse, delayed pulse and delayed input sample, plus static set and cancel.
- Each command is accepted through a valid/ready handshake and finishes with exactly one tagged response.
- Sits between the instruction decoder and the pad-level output_io/input_io buses.

Parameters:
- OUTPUTS, 32, output pin count; must equal 2**PIN_W.
- INPUTS, 32, input pin count; must equal 2**PIN_W.
- PIN_W, 5, pin index width.
- CHANNELS, 4, concurrent timer channels (1..8).
- CH_W, 2, channel index width, clog2(CHANNELS), minimum 1.
- TIMER_W, 44, delay/hold counter width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command can be accepted.
- cmd_op  in  3  opcode.
- cmd_pin  in  PIN_W  target pin.
- cmd_delay  in  TIMER_W  pre-action delay, in cycles.
- cmd_hold  in  TIMER_W  pulse high time, in cycles.
- cmd_level  in  1  level for SET.
- input_io  in  INPUTS  pad inputs.
- output_io  out  OUTPUTS  pad outputs, registered.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_imm  out  1  response belongs to an immediate op.
- rsp_chan  out  CH_W  channel that produced the response (0 when rsp_imm=1).
- rsp_data  out  1  sampled input bit (SAMPLE only, else 0).
- rsp_err  out  1  command rejected.
- busy  out  1  at least one channel is not IDLE.

Behaviour:
- Reset (sync, rst=1 at a rising edge):
  - output_io=0, rsp_valid=0, rsp_imm=0, rsp_chan=0, rsp_data=0, rsp_err=0, busy=0.
  - All channels go to IDLE and any pending response is dropped.
  - Reset mid-pulse drops the pin to 0 on the same edge.
- Handshake:
  - cmd_ready = 1 when any channel is IDLE; this gates every opcode.
  - A command is accepted on an edge where cmd_valid and cmd_ready are both 1; at most one per cycle.
  - cmd_* fields are captured at acceptance.
- Opcodes:
  - 000 PULSE: allocate a channel, hold pin high for H cycles.
  - 001 DPULSE: allocate a channel, wait D cycles, then hold pin high for H cycles.
  - 010 SET: output_io[pin] <= cmd_level; immediate.
  - 011 SAMPLE: allocate a channel, wait D cycles, sample input_io[pin].
  - 100 CANCEL: immediate; see Conflicts.
  - 101..111: rejected with an immediate response, rsp_err=1.
- Allocation:
  - The lowest-index IDLE channel is allocated.
  - The channel records pin, op, D and H. H=0 is treated as H=1.
- Channel states: IDLE, DELAY, HOLD, DONE.
  - Accept: DELAY if D>0, else HOLD for pulse ops; SAMPLE with D=0 goes straight to the sample edge.
  - DELAY: counter loads D and decrements each cycle. When it reaches 0, a pulse op sets the pin high and enters HOLD; SAMPLE captures input_io[pin] and enters DONE.
  - HOLD: counter loads H. The pin goes high on the edge the channel enters HOLD and is cleared on the edge it leaves HOLD for DONE.
  - DONE: wait for the response grant, then IDLE.
- Timing:
  - PULSE accepted at edge 0: pin high in cycles 1..H, low from cycle H+1.
  - DPULSE accepted at edge 0: pin high in cycles D+1..D+H.
  - SAMPLE accepted at edge 0: input captured at edge D+1.
- Responses:
  - One registered response per cycle.
  - Priority: the pending immediate response first, then DONE channels lowest index first.
  - An immediate op responds one cycle after acceptance; it can never stall, since only one accept happens per cycle.
  - Channel response latency is therefore 1 cycle minimum after DONE, plus arbitration wait.
  - A channel in DONE is not free.
- Conflicts:
  - PULSE, DPULSE or SET to a pin owned by a non-IDLE pulse channel: no allocation, output unchanged, immediate response with rsp_err=1.
  - SAMPLE never conflicts.
  - CANCEL on an owned pin: that channel's pin goes to 0 and the channel goes to IDLE with no channel response; immediate response rsp_err=0.
  - CANCEL on an unowned pin: rsp_err=1, no state change.
  - CANCEL on a channel in DONE: discards its pending response.
- Simultaneous events:
  - A channel going IDLE frees its slot for acceptance on the next edge; cmd_ready is computed from registered state.
  - Two channels finishing together are both served in index order on consecutive cycles.
- Widths:
  - Counters are TIMER_W bits, decrement-only, with no wrap.
  - Maximum delay or hold is 2**TIMER_W-1 cycles.

Test Plan:
- PULSE pin 3, H=4, accepted at edge 0 -> output_io[3]=1 in cycles 1..4, 0 at cycle 5; response rsp_chan=0, rsp_err=0 at cycle 6.
- DPULSE pin 7, D=10, H=2, then SAMPLE pin 9 with input_io[9]=1, D=0 -> channels 0 and 1 used; SAMPLE response rsp_data=1 first, pin 7 high in cycles 11..12.
- Four PULSEs with H=100 on pins 0..3 -> cmd_ready=0 and busy=1 after the fourth accept; a fifth command stalls until the first channel's response.
- PULSE pin 5, H=50, then SET pin 5 level 1 -> rsp_imm=1, rsp_err=1, pulse unaffected; CANCEL pin 5 at cycle 20 -> pin 0 next cycle, rsp_err=0, no channel response.
- Opcode 110 -> rsp_imm=1, rsp_err=1, no channel allocated; CANCEL pin 12 with no owner -> rsp_err=1.
- rst=1 during HOLD of a pulse on pin 2 -> output_io[2]=0 and busy=0 after that edge, no response emitted.
